// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM that steps one instruction through T0..T3
// and drives register-file enables, bus selects and the ALU op code.
module alu_sequencer #(
    parameter int          DATA_W = 16,
    parameter int          NREG   = 8,
    parameter logic [3:0]  OP_MV  = 4'd0,
    parameter logic [3:0]  OP_MVI = 4'd1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_irin,
    output logic [NREG-1:0]   o_rin,
    output logic [NREG-1:0]   o_rout,
    output logic              o_dinout,
    output logic              o_ain,
    output logic              o_gin,
    output logic              o_gout,
    output logic [3:0]        o_alu_op,
    output logic              o_done,
    output logic              o_illegal
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_ir;
    logic [3:0]        w_op;
    logic [NREG-1:0]   w_rx, w_ry;
    logic              w_alu;
    logic              w_unused;

    assign w_op     = r_ir[15:12];
    assign w_rx     = NREG'(1) << r_ir[11:9];
    assign w_ry     = NREG'(1) << r_ir[8:6];
    assign w_alu    = (w_op >= 4'd5) && (w_op <= 4'd10);
    assign w_unused = ^r_ir[5:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (o_irin) r_ir <= i_din;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_irin    = 1'b0;
        o_rin     = '0;
        o_rout    = '0;
        o_dinout  = 1'b0;
        o_ain     = 1'b0;
        o_gin     = 1'b0;
        o_gout    = 1'b0;
        o_alu_op  = 4'd0;
        o_done    = 1'b0;
        o_illegal = 1'b0;
        case (r_state)
            T0: begin
                o_irin = i_run;
                w_next = i_run ? T1 : T0;
            end
            T1: begin
                if (w_op == OP_MV) begin
                    o_rout = w_ry;
                    o_rin  = w_rx;
                    o_done = 1'b1;
                    w_next = T0;
                end else if (w_op == OP_MVI) begin
                    o_dinout = 1'b1;
                    o_rin    = w_rx;
                    o_done   = 1'b1;
                    w_next   = T0;
                end else if (w_alu) begin
                    o_rout = w_rx;
                    o_ain  = 1'b1;
                    w_next = T2;
                end else begin
                    o_done    = 1'b1;
                    o_illegal = 1'b1;
                    w_next    = T0;
                end
            end
            T2: begin
                o_rout   = w_ry;
                o_gin    = 1'b1;
                o_alu_op = w_op;
                w_next   = T3;
            end
            T3: begin
                o_gout = 1'b1;
                o_rin  = w_rx;
                o_done = 1'b1;
                w_next = T0;
            end
        endcase
        // Reset masks every strobe so nothing is written while the datapath settles.
        if (i_rst) begin
            o_irin    = 1'b0;
            o_rin     = '0;
            o_rout    = '0;
            o_dinout  = 1'b0;
            o_ain     = 1'b0;
            o_gin     = 1'b0;
            o_gout    = 1'b0;
            o_alu_op  = 4'd0;
            o_done    = 1'b0;
            o_illegal = 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; stimulus pushes the expected per-cycle control
// words of each instruction, a negedge monitor pops them whenever the DUT drives anything.
module tb_alu_sequencer;
    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu_op;
        logic       done;
        logic       illegal;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] din = '0;
    logic        irin, dinout, ain, gin, gout, done, illegal;
    logic [7:0]  rin, rout;
    logic [3:0]  alu_op;

    out_t q[$];
    int   tests = 0;
    int   fails = 0;

    alu_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_din(din),
        .o_irin(irin), .o_rin(rin), .o_rout(rout), .o_dinout(dinout),
        .o_ain(ain), .o_gin(gin), .o_gout(gout), .o_alu_op(alu_op),
        .o_done(done), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected control words derived straight from the instruction's meaning.
    function automatic int push_expected(input logic [15:0] ins);
        out_t       e;
        logic [3:0] op = ins[15:12];
        logic [7:0] x  = 8'd1 << ins[11:9];
        logic [7:0] y  = 8'd1 << ins[8:6];
        e = '0; e.irin = 1'b1; q.push_back(e);
        if (op == 4'd0) begin
            e = '0; e.rout = y; e.rin = x; e.done = 1'b1; q.push_back(e);
            return 2;
        end
        if (op == 4'd1) begin
            e = '0; e.dinout = 1'b1; e.rin = x; e.done = 1'b1; q.push_back(e);
            return 2;
        end
        if (op >= 4'd5 && op <= 4'd10) begin
            e = '0; e.rout = x; e.ain = 1'b1; q.push_back(e);
            e = '0; e.rout = y; e.gin = 1'b1; e.alu_op = op; q.push_back(e);
            e = '0; e.gout = 1'b1; e.rin = x; e.done = 1'b1; q.push_back(e);
            return 4;
        end
        e = '0; e.done = 1'b1; e.illegal = 1'b1; q.push_back(e);
        return 2;
    endfunction

    task automatic exec(input logic [15:0] ins, input logic [15:0] imm);
        int n;
        n = push_expected(ins);
        run = 1'b1;
        din = ins;
        @(posedge clk); #1;
        for (int i = 1; i < n; i++) begin
            run = 1'($urandom);
            din = (i == 1) ? imm : 16'($urandom);
            @(posedge clk); #1;
        end
        run = 1'b0;
    endtask

    task automatic idle(input int n);
        run = 1'b0;
        din = 16'($urandom);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        out_t act, exp;
        act = '{irin, rin, rout, dinout, ain, gin, gout, alu_op, done, illegal};
        tests++;
        if ($countones({rout, dinout, gout}) > 1) begin
            fails++;
            $display("FAIL onehot: bus selects rout=%h dinout=%b gout=%b, required at most one", rout, dinout, gout);
        end
        if (act != '0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected @%0t: got %h, required %h (idle)", $time, act, 27'd0);
            end else begin
                exp = q.pop_front();
                if (act != exp) begin
                    fails++;
                    $display("FAIL seq @%0t: got %h, required %h", $time, act, exp);
                end
            end
        end
    end

    initial begin
        // Reset held with Run high: nothing may fire.
        run = 1'b1;
        din = 16'h52C0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        idle(3);
        exec(16'h0540, 16'h0000);
        exec(16'h1800, 16'hBEEF);
        idle(1);
        exec(16'h52C0, 16'h1234);
        exec(16'h61C0, 16'h4321);
        for (int op = 7; op <= 10; op++) exec({4'(op), 3'(op - 5), 3'(op - 6), 6'h15}, 16'h0);
        exec(16'h3000, 16'hFFFF);
        idle(2);
        // Reset landing in T2 of an add: only T0/T1 words are expected.
        void'(q.size());
        begin
            out_t e;
            e = '0; e.irin = 1'b1; q.push_back(e);
            e = '0; e.rout = 8'h02; e.ain = 1'b1; q.push_back(e);
        end
        run = 1'b1; din = 16'h52C0;
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        idle(3);
        exec(16'h0540, 16'h0000);
        // Back-to-back with Run held high.
        exec(16'h52C0, 16'h0);
        exec(16'h1E00, 16'hA5A5);
        exec(16'hA7C0, 16'h0);
        idle(2);
        for (int k = 0; k < 60; k++) begin
            exec(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected words left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
